// File: rtl/ex_mem_skid.sv
// Two-entry skid buffer between execute and memory stages.
// Ready and valid are decoded from the state register only, so no combinational path runs back into the ALU.
module ex_mem_skid #(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_result,
    input  logic          in_ofl,
    input  logic          in_zero,
    input  logic [RW-1:0] in_wr_reg,
    input  logic          in_wr_en,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_result,
    output logic          out_ofl,
    output logic          out_zero,
    output logic [RW-1:0] out_wr_reg,
    output logic          out_wr_en,
    output logic [1:0]    count
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    typedef struct packed {
        logic [DW-1:0] result;
        logic          ofl;
        logic          zero;
        logic [RW-1:0] wr_reg;
        logic          wr_en;
    } ent_t;

    state_t state_q, state_d;
    ent_t   head_q, head_d;
    ent_t   skid_q, skid_d;
    ent_t   in_ent;
    logic   push, pop;

    assign in_ent    = {in_result, in_ofl, in_zero, in_wr_reg, in_wr_en};
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Registers load only on an accepted push, so don't-care inputs never reach out_*.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        head_d  = in_ent;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_d = in_ent;
                    end else if (push) begin
                        skid_d  = in_ent;
                        state_d = FULL;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    assign out_result = head_q.result;
    assign out_ofl    = head_q.ofl;
    assign out_zero   = head_q.zero;
    assign out_wr_reg = head_q.wr_reg;
    // A stale head left behind by a flush must never write back.
    assign out_wr_en  = head_q.wr_en & out_valid;
    assign count      = state_q;

endmodule

// File: tb/tb_ex_mem_skid.sv
// Scoreboard bench for ex_mem_skid: the driver queues accepted words, and the monitor checks every word the memory stage consumes.
module tb_ex_mem_skid;
    localparam int DW = 16;
    localparam int RW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_result = '0;
    logic          in_ofl = 1'b0;
    logic          in_zero = 1'b0;
    logic [RW-1:0] in_wr_reg = '0;
    logic          in_wr_en = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_result;
    logic          out_ofl;
    logic          out_zero;
    logic [RW-1:0] out_wr_reg;
    logic          out_wr_en;
    logic [1:0]    count;

    typedef struct packed {
        logic [DW-1:0] r;
        logic          o;
        logic          z;
        logic [RW-1:0] g;
        logic          e;
    } ent_t;

    ent_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    ex_mem_skid #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_ofl(in_ofl), .in_zero(in_zero), .in_wr_reg(in_wr_reg), .in_wr_en(in_wr_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_ofl(out_ofl), .out_zero(out_zero), .out_wr_reg(out_wr_reg),
        .out_wr_en(out_wr_en), .count(count)
    );

    always #5 clk = ~clk;

    function automatic ent_t mk(logic [DW-1:0] r, logic o, logic z, logic [RW-1:0] g, logic e);
        mk = {r, o, z, g, e};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a consumed head must match the oldest accepted word.
    always @(negedge clk) begin
        if (!out_valid) chk("wr_en_gated", {31'd0, out_wr_en}, 32'd0);
        if (rst_n && out_valid && out_ready && !flush) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_out: got %0h expected no output", out_result);
            end else begin
                ent_t e;
                e = sb.pop_front();
                chk("mon_result", {16'd0, out_result}, {16'd0, e.r});
                chk("mon_ofl", {31'd0, out_ofl}, {31'd0, e.o});
                chk("mon_zero", {31'd0, out_zero}, {31'd0, e.z});
                chk("mon_wr_reg", {29'd0, out_wr_reg}, {29'd0, e.g});
                chk("mon_wr_en", {31'd0, out_wr_en}, {31'd0, e.e});
            end
        end
    end

    // One cycle of stimulus, started just after a rising edge and ending just after the next one.
    task automatic step(input logic v, input ent_t d, input logic ordy, input logic fl = 1'b0);
        logic acc;
        in_valid = v;
        {in_result, in_ofl, in_zero, in_wr_reg, in_wr_en} = d;
        out_ready = ordy;
        flush = fl;
        @(negedge clk);
        acc = v && in_ready && !fl;
        @(posedge clk);
        if (acc) sb.push_back(d);
        if (fl) sb.delete();
        #1;
        flush = 1'b0;
    endtask

    ent_t junk;

    initial begin
        junk = mk(16'hDEAD, 1'b1, 1'b1, 3'd7, 1'b1);

        // Reset held with a pending input.
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_result = 16'hFFFF;
        in_wr_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_count", {30'd0, count}, 32'd0);
        chk("rst_out_result", {16'd0, out_result}, 32'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Passthrough, then a back-to-back stream.
        step(1'b1, mk(16'h1234, 1'b0, 1'b0, 3'd3, 1'b1), 1'b1);
        chk("pt_valid", {31'd0, out_valid}, 32'd1);
        chk("pt_result", {16'd0, out_result}, 32'h1234);
        chk("pt_wr_reg", {29'd0, out_wr_reg}, 32'd3);
        chk("pt_wr_en", {31'd0, out_wr_en}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            logic [2:0] k;
            k = 3'(i);
            step(1'b1, mk(16'h0100 + 16'(i), k[0], k[1], k, ~k[2]), 1'b1);
            chk("pt_count", {30'd0, count}, 32'd1);
            chk("pt_stream_result", {16'd0, out_result}, 32'h0100 + 32'(i));
        end
        step(1'b0, junk, 1'b1);
        chk("pt_drain_count", {30'd0, count}, 32'd0);

        // Stall fill, blocked third push, then drain in order.
        step(1'b1, mk(16'hAAAA, 1'b1, 1'b0, 3'd1, 1'b1), 1'b0);
        chk("st_count1", {30'd0, count}, 32'd1);
        step(1'b1, mk(16'h5555, 1'b0, 1'b1, 3'd2, 1'b1), 1'b0);
        chk("st_count2", {30'd0, count}, 32'd2);
        chk("st_in_ready", {31'd0, in_ready}, 32'd0);
        chk("st_head", {16'd0, out_result}, 32'hAAAA);
        step(1'b1, mk(16'h0C0C, 1'b0, 1'b0, 3'd4, 1'b0), 1'b0);
        chk("st_held_count", {30'd0, count}, 32'd2);
        chk("st_held_head", {16'd0, out_result}, 32'hAAAA);
        step(1'b1, mk(16'h0C0C, 1'b0, 1'b0, 3'd4, 1'b0), 1'b1);
        chk("st_pop1_head", {16'd0, out_result}, 32'h5555);
        chk("st_pop1_count", {30'd0, count}, 32'd1);
        step(1'b1, mk(16'h0C0C, 1'b0, 1'b0, 3'd4, 1'b0), 1'b1);
        chk("st_pop2_head", {16'd0, out_result}, 32'h0C0C);
        step(1'b0, junk, 1'b1);
        chk("st_empty", {30'd0, count}, 32'd0);

        // Simultaneous push and pop while holding one entry.
        step(1'b1, mk(16'h0001, 1'b0, 1'b0, 3'd1, 1'b1), 1'b0);
        step(1'b1, mk(16'h0002, 1'b1, 1'b1, 3'd2, 1'b0), 1'b1);
        chk("pp_count", {30'd0, count}, 32'd1);
        chk("pp_head", {16'd0, out_result}, 32'h0002);
        chk("pp_ofl", {31'd0, out_ofl}, 32'd1);
        chk("pp_zero", {31'd0, out_zero}, 32'd1);
        chk("pp_wr_en", {31'd0, out_wr_en}, 32'd0);
        step(1'b0, junk, 1'b1);

        // Flush from FULL with a push and a pop in the same cycle.
        step(1'b1, mk(16'h1111, 1'b0, 1'b0, 3'd5, 1'b1), 1'b0);
        step(1'b1, mk(16'h2222, 1'b0, 1'b0, 3'd6, 1'b1), 1'b0);
        chk("fl_pre_count", {30'd0, count}, 32'd2);
        step(1'b1, mk(16'h3333, 1'b0, 1'b0, 3'd7, 1'b1), 1'b1, 1'b1);
        chk("fl_count", {30'd0, count}, 32'd0);
        chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_wr_en", {31'd0, out_wr_en}, 32'd0);
        chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (3) step(1'b0, junk, 1'b1);

        // Asynchronous reset between edges while FULL.
        step(1'b1, mk(16'h4444, 1'b1, 1'b0, 3'd2, 1'b1), 1'b0);
        step(1'b1, mk(16'h6666, 1'b0, 1'b1, 3'd3, 1'b1), 1'b0);
        chk("ar_pre_count", {30'd0, count}, 32'd2);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("ar_out_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_count", {30'd0, count}, 32'd0);
        chk("ar_result", {16'd0, out_result}, 32'd0);
        chk("ar_wr_en", {31'd0, out_wr_en}, 32'd0);
        chk("ar_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, mk(16'hBEEF, 1'b0, 1'b1, 3'd6, 1'b1), 1'b1);
        chk("ar_pt_result", {16'd0, out_result}, 32'hBEEF);
        chk("ar_pt_count", {30'd0, count}, 32'd1);
        step(1'b0, junk, 1'b1);
        step(1'b0, junk, 1'b1);

        chk("sb_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
